// File: rtl/demux_rr_dispatch.sv
// Round-robin dispatcher feeding a 1-to-4 demux through a one-entry hold register.
// Optional per-channel delivery counters are built when DEMUX_STATS_EN is defined.
module demux_rr_dispatch #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    input  logic [3:0]          chan_en,
    input  logic [3:0]          chan_rdy,
    input  logic                flush,
    output logic [1:0]          sel,
    output logic [DATA_W-1:0]   out_data,
    output logic [3:0]          out_valid,
    output logic                err_timeout,
    output logic [7:0]          drop_cnt,
    output logic [4*CNT_W-1:0]  stat_cnt
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state;
    state_t            state_nx;
    logic [1:0]        rr_ptr;
    logic [1:0]        sel_new;
    logic [WAIT_W-1:0] wait_cnt;
    logic              hold;
    logic              retire;
    logic              accept;
    logic              flush_drop;
    logic              timeout_drop;
    logic              found;

    assign hold         = (state == HOLD);
    assign retire       = hold && chan_rdy[sel];
    assign in_ready     = !flush && (chan_en != 4'b0000) && (!hold || retire);
    assign accept       = in_valid && in_ready;
    assign flush_drop   = hold && flush;
    assign timeout_drop = (TIMEOUT != 0) && hold && !retire && !flush
                          && (wait_cnt == WAIT_LAST);
    assign out_valid    = hold ? (4'b0001 << sel) : 4'b0000;

    // First enabled channel at or after rr_ptr, wrapping mod 4
    always_comb begin
        sel_new = rr_ptr;
        found   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && chan_en[rr_ptr + 2'(k)]) begin
                sel_new = rr_ptr + 2'(k);
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = HOLD;
            HOLD: begin
                if (flush_drop || timeout_drop) state_nx = IDLE;
                else if (accept)                state_nx = HOLD;
                else if (retire)                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= 2'd0;
            sel      <= 2'd0;
            out_data <= '0;
            wait_cnt <= '0;
        end else if (accept) begin
            sel      <= sel_new;
            rr_ptr   <= sel_new + 2'd1;
            out_data <= in_data;
            wait_cnt <= '0;
        end else if (hold && !retire) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
            drop_cnt    <= 8'd0;
        end else begin
            if (timeout_drop)
                err_timeout <= 1'b1;
            if ((flush_drop || timeout_drop) && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

`ifdef DEMUX_STATS_EN
    // A flushed beat never counts as delivered, even if its channel was ready
    logic deliver;
    assign deliver = retire && !flush;

    for (genvar i = 0; i < 4; i++) begin : g_stat
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt <= '0;
            else if (deliver && sel == 2'(i) && !(&cnt))
                cnt <= cnt + 1'b1;
        end
        assign stat_cnt[i*CNT_W +: CNT_W] = cnt;
    end
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_rr_dispatch.sv
// Bench for demux_rr_dispatch: directed vectors against a behavioural
// hold-register model, plus literal expectations that pin the model.
module tb_demux_rr_dispatch;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               in_ready;
    logic [3:0]         chan_en;
    logic [3:0]         chan_rdy;
    logic               flush;
    logic [1:0]         sel;
    logic [DATA_W-1:0]  out_data;
    logic [3:0]         out_valid;
    logic               err_timeout;
    logic [7:0]         drop_cnt;
    logic [4*CNT_W-1:0] stat_cnt;

    int checks = 0;
    int errors = 0;

    demux_rr_dispatch #(
        .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .chan_en(chan_en), .chan_rdy(chan_rdy), .flush(flush),
        .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .err_timeout(err_timeout), .drop_cnt(drop_cnt), .stat_cnt(stat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: is a beat held, which channel, its data, how long it has waited
    bit        m_held;
    int        m_ch;
    int        m_data;
    int        m_wait;
    int        m_rr;
    bit        m_err;
    int        m_drops;
    int        m_stats[4];
    bit        m_ir;
    bit        m_pick_done;

    function automatic bit exp_ready();
        if (flush || chan_en == 4'b0000) return 1'b0;
        if (!m_held) return 1'b1;
        return chan_rdy[m_ch];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_held  = 0;
            m_ch    = 0;
            m_data  = 0;
            m_wait  = 0;
            m_rr    = 0;
            m_err   = 0;
            m_drops = 0;
            for (int i = 0; i < 4; i++) m_stats[i] = 0;
        end else begin
            m_ir = exp_ready();
            if (m_held && flush) begin
                m_held = 0;
                if (m_drops < 255) m_drops++;
            end else begin
                if (m_held && chan_rdy[m_ch]) begin
                    if (m_stats[m_ch] < 65535) m_stats[m_ch]++;
                    m_held = 0;
                end else if (m_held) begin
                    m_wait++;
                    if (TIMEOUT != 0 && m_wait == TIMEOUT) begin
                        m_held = 0;
                        m_err  = 1;
                        if (m_drops < 255) m_drops++;
                    end
                end
                if (in_valid && m_ir) begin
                    m_pick_done = 0;
                    for (int k = 0; k < 4; k++) begin
                        if (!m_pick_done && chan_en[(m_rr + k) % 4]) begin
                            m_ch = (m_rr + k) % 4;
                            m_pick_done = 1;
                        end
                    end
                    m_rr   = (m_ch + 1) % 4;
                    m_data = int'(in_data);
                    m_held = 1;
                    m_wait = 0;
                end
            end
        end
    end

    function automatic logic [63:0] exp_stats();
        logic [63:0] v;
        v = '0;
`ifdef DEMUX_STATS_EN
        for (int i = 0; i < 4; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_stats[i]);
`endif
        return v;
    endfunction

    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(exp_ready()));
        chk("out_valid", 64'(out_valid), m_held ? 64'(1 << m_ch) : 64'd0);
        if (m_held) begin
            chk("sel", 64'(sel), 64'(m_ch));
            chk("out_data", 64'(out_data), 64'(m_data));
        end
        chk("err_timeout", 64'(err_timeout), 64'(m_err));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
        chk("stat_cnt", stat_cnt, exp_stats());
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int held_cycles;
    logic [3:0] ovexp;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        chan_en  = 4'hF;
        chan_rdy = 4'hF;
        flush    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

        // Back-to-back beats over all channels
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(8'h10 + i);
            #1;
            chk("t1_in_ready", 64'(in_ready), 64'd1);
            step();
            ovexp = 4'b0001 << (i % 4);
            chk("t1_sel", 64'(sel), 64'(i % 4));
            chk("t1_data", 64'(out_data), 64'(8'h10 + i));
            chk("t1_out_valid", 64'(out_valid), 64'(ovexp));
        end
        in_valid = 1'b0;
        step();

        // Only channels 1 and 3 enabled
        chan_en  = 4'b1010;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'h20 + i);
            step();
            chk("t2_sel", 64'(sel), (i % 2 == 0) ? 64'd1 : 64'd3);
            chk("t2_out_valid", 64'(out_valid), (i % 2 == 0) ? 64'h2 : 64'h8);
        end
        in_valid = 1'b0;
        step();
        chan_en = 4'hF;

        // Timeout on channel 0
        chan_rdy = 4'b1110;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_valid = 1'b0;
        held_cycles = 0;
        while (out_valid == 4'b0001 && held_cycles < 40) begin
            held_cycles++;
            step();
        end
        chk("t3_held_cycles", 64'(held_cycles), 64'd16);
        chk("t3_out_valid", 64'(out_valid), 64'd0);
        chk("t3_err", 64'(err_timeout), 64'd1);
        chk("t3_drop", 64'(drop_cnt), 64'd1);
        chk("t3_in_ready", 64'(in_ready), 64'd1);

        // Flush a beat held on channel 2
        chan_rdy = 4'b0000;
        chan_en  = 4'b0100;
        in_valid = 1'b1;
        in_data  = 8'h42;
        step();
        chk("t4_sel", 64'(sel), 64'd2);
        chan_en = 4'hF;
        flush   = 1'b1;
        in_data = 8'h43;
        #1;
        chk("t4_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("t4_out_valid", 64'(out_valid), 64'd0);
        chk("t4_drop", 64'(drop_cnt), 64'd2);
        flush    = 1'b0;
        chan_rdy = 4'hF;
        step();
        chk("t4_next_sel", 64'(sel), 64'd3);
        in_valid = 1'b0;
        step();

        // Asynchronous reset while a beat is held
        chan_rdy = 4'b0000;
        in_valid = 1'b1;
        in_data  = 8'h55;
        step();
        in_valid = 1'b0;
        step();
        chk("t5_pre_valid", 64'(out_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_drop", 64'(drop_cnt), 64'd0);
        chk("t5_err", 64'(err_timeout), 64'd0);
        step();
        rst_n    = 1'b1;
        chan_rdy = 4'hF;

        // Five delivered beats after reset
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'h60 + i);
            step();
            chk("t6_sel", 64'(sel), 64'(i % 4));
        end
        in_valid = 1'b0;
        step();
`ifdef DEMUX_STATS_EN
        chk("t6_stat", stat_cnt, 64'h0001_0001_0001_0002);
`else
        chk("t6_stat", stat_cnt, 64'd0);
`endif

        // drop_cnt saturation
        chan_rdy = 4'b0000;
        for (int i = 0; i < 258; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
            in_valid = 1'b0;
            flush    = 1'b1;
            step();
            flush = 1'b0;
        end
        chk("t7_drop_sat", 64'(drop_cnt), 64'd255);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
